// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR3 example-design self-test traffic generators:
// FSM encodings, AXI constants and the pattern LFSR parameters.
package ddr_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int LANES = 8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/test_wr_data_gen.sv
// Per-beat write data builder: LFSR-keyed address pattern or the fixed
// FFFF/0000 alternating lane pattern.
module test_wr_data_gen
  import ddr_test_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         data_pattern_01,
  input  logic [7:0]   word_addr,
  output logic [127:0] data
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (data_pattern_01)
        data[16*i +: 16] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      else
        data[16*i +: 16] = {lfsr_q, lfsr_q ^ (word_addr + 8'(i))};
    end
  end

endmodule

// File: rtl/test_wr_ctrl_128bit.sv
// AXI4 single-burst write traffic generator for the DDR3 self test; fills each
// 128-bit beat with the pattern the read checker expects.
module test_wr_ctrl_128bit
  import ddr_test_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH    = 28,
  parameter int MEM_DQ_WIDTH       = 16,
  parameter int MEM_COL_ADDR_WIDTH = 10,
  parameter int MEM_SPACE_AW       = 18
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  input  logic [3:0]                 random_axi_id,
  input  logic [3:0]                 random_axi_len,
  input  logic                       write_en,
  input  logic                       data_pattern_01,
  input  logic                       write_double_en,
  output logic                       write_done_p,
  output logic [31:0]                axi_awaddr,
  output logic [7:0]                 axi_awid,
  output logic [7:0]                 axi_awlen,
  output logic [2:0]                 axi_awsize,
  output logic [1:0]                 axi_awburst,
  output logic                       axi_awlock,
  output logic [3:0]                 axi_awqos,
  output logic                       axi_awpoison,
  output logic                       axi_awurgent,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [127:0]               axi_wdata,
  output logic [15:0]                axi_wstrb,
  output logic                       axi_wlast,
  output logic                       axi_wvalid,
  input  logic                       axi_wready,
  input  logic [7:0]                 axi_bid,
  input  logic [1:0]                 axi_bresp,
  input  logic                       axi_bvalid,
  output logic                       axi_bready,
  output logic [7:0]                 bresp_err_cnt
);

  wr_state_e   state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [3:0]  awid_q, awid_d;
  logic [3:0]  awlen_q, awlen_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]  word_addr_q, word_addr_d;
  logic        burst_par_q, burst_par_d;
  logic        done_q, done_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        last_beat;
  logic        unused_ok;

  assign last_beat = (beat_cnt_q == awlen_q);

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awid_d      = awid_q;
    awlen_d     = awlen_q;
    beat_cnt_d  = beat_cnt_q;
    word_addr_d = word_addr_q;
    burst_par_d = burst_par_q;
    done_d      = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (write_en) begin
          state_d     = ST_AW;
          awaddr_d    = {{(31-CTRL_ADDR_WIDTH){1'b0}}, random_rw_addr, 1'b0};
          awid_d      = random_axi_id;
          awlen_d     = random_axi_len;
          beat_cnt_d  = '0;
          word_addr_d = random_rw_addr[7:0];
        end
      end
      ST_AW: begin
        if (axi_awready) state_d = ST_W;
      end
      ST_W: begin
        if (axi_wready) begin
          beat_cnt_d  = beat_cnt_q + 4'd1;
          word_addr_d = word_addr_q + 8'd8;
          if (last_beat) state_d = ST_B;
        end
      end
      ST_B: begin
        if (axi_bvalid) begin
          state_d = ST_IDLE;
          if (axi_bresp != RESP_OKAY && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
          burst_par_d = ~burst_par_q;
          // In double mode only the second of each burst pair reports done
          done_d = !write_double_en || burst_par_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      awaddr_q    <= '0;
      awid_q      <= '0;
      awlen_q     <= '0;
      beat_cnt_q  <= '0;
      word_addr_q <= '0;
      burst_par_q <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      awid_q      <= awid_d;
      awlen_q     <= awlen_d;
      beat_cnt_q  <= beat_cnt_d;
      word_addr_q <= word_addr_d;
      burst_par_q <= burst_par_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  test_wr_data_gen u_data_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .adv             ((state_q == ST_W) && axi_wready),
    .data_pattern_01 (data_pattern_01),
    .word_addr       (word_addr_q),
    .data            (axi_wdata)
  );

  assign axi_awaddr    = awaddr_q;
  assign axi_awid      = {4'b0, awid_q};
  assign axi_awlen     = {4'b0, awlen_q};
  assign axi_awsize    = SIZE_16B;
  assign axi_awburst   = BURST_INCR;
  assign axi_awlock    = 1'b0;
  assign axi_awqos     = 4'b0;
  assign axi_awpoison  = 1'b0;
  assign axi_awurgent  = 1'b0;
  assign axi_awvalid   = (state_q == ST_AW);
  assign axi_wvalid    = (state_q == ST_W);
  assign axi_wlast     = axi_wvalid && last_beat;
  assign axi_wstrb     = 16'hFFFF;
  assign axi_bready    = 1'b1;
  assign write_done_p  = done_q;
  assign bresp_err_cnt = err_cnt_q;

  // Response ID and parity-only parameters have no function in this generator
  assign unused_ok = ^{axi_bid, MEM_DQ_WIDTH[0], MEM_COL_ADDR_WIDTH[0], MEM_SPACE_AW[0]};

endmodule
